hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard scheduler for the five-stage MIPS core. Consumes the per-instruction Tuse/Tnew/register-address tuple produced by the D-stage decoder. Tracks in-flight producers through E, M and W, then issues the D-stage stall, the D/E-stage forwarding selects and the multiply/divide busy interlock. Sits between the decoder and the pipeline-register enables/clears.

## Interface
- MULT_CYC, 5: E-stage cycles a mult/multu occupies HI/LO.
- DIV_CYC, 10: E-stage cycles a div/divu occupies HI/LO.
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all tracking state.
- Tuse_rs, Tuse_rt  in  2  D-stage use time; 2'b11 means the operand is unused.
- TnewD  in  2  D-stage produce time (0 = no result).
- A_rsD, A_rtD, AwriteD  in  5 each  D-stage source and destination registers; 0 means none.
- md_startD  in  1  D instruction is mult/multu/div/divu.
- md_divD  in  1  qualifies md_startD as a divide.
- md_accessD  in  1  D instruction is mfhi/mflo/mthi/mtlo.
- flush  in  1  exception/eret flush; kills the E and M contents at the next edge.
- stall  out  1  freeze PC and the F/D register, insert a bubble into E.
- fwd_rsD, fwd_rtD  out  2  D-stage select: 0 = regfile, 1 = from M, 2 = from W.
- fwd_rsE, fwd_rtE  out  2  E-stage select, same encoding.
- md_busy  out  1  HI/LO unit is occupied.

## Operation
- Internal records for stages E, M and W: {A_rs, A_rt, Awrite, Tnew}. Also one md down-counter of 4 bits.
- Advance each edge:
  - E <= D tuple with Tnew = sat(TnewD−1), or a bubble (all zero) when stall=1.
  - M <= E with Tnew = sat(TnewE−1).
  - W <= M with Tnew = 0.
- flush=1 forces the E and M records to bubble. flush has priority over stall. The W record still advances normally.
- rs hazard condition: A_rsD≠0, Tuse_rs≠3, and (A_rsD==AwriteE with TnewE>Tuse_rs) or (A_rsD==AwriteM with TnewM>Tuse_rs). The rt hazard condition is identical using rt. No check is made against W.
- md interlock applies when (md_startD|md_accessD) and (md_busy or an md start is currently in E).
- stall = rs hazard | rt hazard | md interlock. stall is combinational.
- D forwarding, fwd_rsD:
  - 1 if A_rsD≠0, A_rsD==AwriteM and TnewM==0.
  - Otherwise 2 if A_rsD==AwriteW.
  - Otherwise 0.
  - fwd_rtD uses the same rules with rt.
- E forwarding uses the same rules applied to A_rsE/A_rtE against the M and W records. The nearer stage always wins.
- md counter:
  - When the E record holds an md start, load MULT_CYC or DIV_CYC.
  - Otherwise decrement while nonzero.
  - md_busy = (counter≠0). The E-stage start flag is tracked alongside the E record and is killed by flush. A counter that is already running is not affected by flush.
- Register 0 never matches: a zero address disables both hazard detection and forwarding.

## Timing
- Reset values: all records and the counter are 0. stall=0 (given idle D inputs), all fwd_*=0, md_busy=0.
- Load followed by a dependent ALU instruction: 1 stall cycle, then fwd_*E=2.
- ALU followed by a dependent beq/jr: 1 stall cycle, then fwd_*D=1.
- Load followed by a dependent beq: 2 stall cycles, then fwd_*D=2.
- Back-to-back independent instructions: 0 stalls.
- md_busy rises the edge after the md start leaves D. It stays high MULT_CYC or DIV_CYC cycles.
- Reset asserted mid-stall: outputs clear immediately (asynchronous), with no residual bubble.
- Simultaneous flush and stall: E and M are bubbled. The stall releases on the next cycle if its cause was in E or M.

## Test plan
- Decode lw $3 and then addu $4,$3,$5 → stall=1 for exactly 1 cycle; next cycle fwd_rsE=2, and M-to-W carries Awrite=3.
- Decode addu $2 and then beq $2,$0 → stall 1 cycle; then fwd_rsD=1, fwd_rtD=0.
- Decode lw $7, nop, then jr $7 → stall 1 cycle, then fwd_rsD=2.
- Decode mult and then mflo → stall for 1+MULT_CYC (6) cycles, md_busy high for 5; a div gives 11 stall cycles.
- lw $3 with flush asserted while the lw sits in E, then addu $4,$3 → no stall, fwd_rsE=0.
- Drop reset low during a load-use stall → stall=0, fwd_*=0, md_busy=0 immediately; after release, $0-destined writers never cause a stall.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Decoder-to-hazard-scheduler bundle: D-stage tuple and flush in,
// stall / forwarding selects / HI-LO busy out.
interface hazard_ctrl_if;
  logic [1:0] Tuse_rs;
  logic [1:0] Tuse_rt;
  logic [1:0] TnewD;
  logic [4:0] A_rsD;
  logic [4:0] A_rtD;
  logic [4:0] AwriteD;
  logic       md_startD;
  logic       md_divD;
  logic       md_accessD;
  logic       flush;
  logic       stall;
  logic [1:0] fwd_rsD;
  logic [1:0] fwd_rtD;
  logic [1:0] fwd_rsE;
  logic [1:0] fwd_rtE;
  logic       md_busy;

  modport master (
    output Tuse_rs, Tuse_rt, TnewD, A_rsD, A_rtD, AwriteD,
           md_startD, md_divD, md_accessD, flush,
    input  stall, fwd_rsD, fwd_rtD, fwd_rsE, fwd_rtE, md_busy
  );

  modport slave (
    input  Tuse_rs, Tuse_rt, TnewD, A_rsD, A_rtD, AwriteD,
           md_startD, md_divD, md_accessD, flush,
    output stall, fwd_rsD, fwd_rtD, fwd_rsE, fwd_rtE, md_busy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Tuse/Tnew hazard scheduler: tracks producers in E/M/W, raises the D-stage
// stall, picks forwarding sources and interlocks the HI/LO multiply/divide unit.
module hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  typedef struct packed {
    logic [4:0] a_rs;
    logic [4:0] a_rt;
    logic [4:0] a_write;
    logic [1:0] tnew;
  } e_rec_t;

  // Source addresses are not kept past E: nothing downstream compares them.
  typedef struct packed {
    logic [4:0] a_write;
    logic [1:0] tnew;
  } m_rec_t;

  e_rec_t     e_q, e_d;
  m_rec_t     m_q, m_d;
  logic [4:0] w_aw_q, w_aw_d;
  logic       e_md_q, e_md_d;
  logic       e_div_q, e_div_d;
  logic [3:0] md_cnt_q, md_cnt_d;

  logic       md_lock;
  logic       stall_w;

  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  function automatic logic hazard(input logic [4:0] a, input logic [1:0] tuse,
                                  input e_rec_t e, input m_rec_t m);
    return (a != 5'd0) && (tuse != 2'b11) &&
           (((a == e.a_write) && (e.tnew > tuse)) ||
            ((a == m.a_write) && (m.tnew > tuse)));
  endfunction

  // M is checked first so the nearer producer wins over W.
  function automatic logic [1:0] fwd_sel(input logic [4:0] a, input m_rec_t m,
                                         input logic [4:0] w_aw);
    logic [1:0] sel;
    sel = 2'd0;
    if (a != 5'd0) begin
      if ((a == m.a_write) && (m.tnew == 2'd0)) sel = 2'd1;
      else if (a == w_aw)                       sel = 2'd2;
    end
    return sel;
  endfunction

  always_comb begin
    md_lock = (hz.md_startD | hz.md_accessD) && ((md_cnt_q != 4'd0) || e_md_q);
    stall_w = hazard(hz.A_rsD, hz.Tuse_rs, e_q, m_q) |
              hazard(hz.A_rtD, hz.Tuse_rt, e_q, m_q) |
              md_lock;
  end

  assign hz.stall   = stall_w;
  assign hz.fwd_rsD = fwd_sel(hz.A_rsD, m_q, w_aw_q);
  assign hz.fwd_rtD = fwd_sel(hz.A_rtD, m_q, w_aw_q);
  assign hz.fwd_rsE = fwd_sel(e_q.a_rs, m_q, w_aw_q);
  assign hz.fwd_rtE = fwd_sel(e_q.a_rt, m_q, w_aw_q);
  assign hz.md_busy = (md_cnt_q != 4'd0);

  always_comb begin
    e_d     = '0;
    e_md_d  = 1'b0;
    e_div_d = 1'b0;
    if (!hz.flush && !stall_w) begin
      e_d.a_rs    = hz.A_rsD;
      e_d.a_rt    = hz.A_rtD;
      e_d.a_write = hz.AwriteD;
      e_d.tnew    = sat_dec(hz.TnewD);
      e_md_d      = hz.md_startD;
      e_div_d     = hz.md_divD;
    end

    m_d = '0;
    if (!hz.flush) begin
      m_d.a_write = e_q.a_write;
      m_d.tnew    = sat_dec(e_q.tnew);
    end

    w_aw_d = m_q.a_write;

    // A running count ignores flush; only the start still sitting in E is killed.
    if (e_md_q)
      md_cnt_d = e_div_q ? 4'(DIV_CYC) : 4'(MULT_CYC);
    else if (md_cnt_q != 4'd0)
      md_cnt_d = md_cnt_q - 4'd1;
    else
      md_cnt_d = 4'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q      <= '0;
      m_q      <= '0;
      w_aw_q   <= 5'd0;
      e_md_q   <= 1'b0;
      e_div_q  <= 1'b0;
      md_cnt_q <= 4'd0;
    end else begin
      e_q      <= e_d;
      m_q      <= m_d;
      w_aw_q   <= w_aw_d;
      e_md_q   <= e_md_d;
      e_div_q  <= e_div_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle vector table plus hand-written
// multiply/divide interlock and asynchronous reset sequences.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if hz();

  hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0] tu_rs;
    logic [1:0] tu_rt;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wr;
    logic       mds;
    logic       mdd;
    logic       mda;
  } ins_t;

  typedef struct {
    ins_t i;
    int   fl;
    int   st;
    int   frsD;
    int   frtD;
    int   frsE;
    int   frtE;
  } vec_t;

  vec_t tbl[$];

  function automatic ins_t mk(int urs, int urt, int tn, int rs, int rt, int wr,
                              int s, int d, int a);
    ins_t x;
    x.tu_rs = 2'(urs); x.tu_rt = 2'(urt); x.tnew = 2'(tn);
    x.rs = 5'(rs); x.rt = 5'(rt); x.wr = 5'(wr);
    x.mds = 1'(s); x.mdd = 1'(d); x.mda = 1'(a);
    return x;
  endfunction

  function automatic ins_t NOP();                    return mk(3, 3, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic ins_t LW(int wr);               return mk(1, 3, 3, 29, 0, wr, 0, 0, 0); endfunction
  function automatic ins_t ALU(int rs, int rt, int wr); return mk(1, 1, 2, rs, rt, wr, 0, 0, 0); endfunction
  function automatic ins_t BR(int rs, int rt);       return mk(0, 0, 0, rs, rt, 0, 0, 0, 0); endfunction
  function automatic ins_t JR(int rs);               return mk(0, 3, 0, rs, 0, 0, 0, 0, 0); endfunction
  function automatic ins_t NOUSE(int rs);            return mk(3, 3, 0, rs, 0, 0, 0, 0, 0); endfunction
  function automatic ins_t MD(int dv);               return mk(1, 1, 0, 8, 9, 0, 1, dv, 0); endfunction
  function automatic ins_t MFLO();                   return mk(3, 3, 2, 0, 0, 10, 0, 0, 1); endfunction

  function automatic vec_t V(ins_t i, int fl, int st, int a, int b, int c, int d);
    vec_t v;
    v.i = i; v.fl = fl; v.st = st;
    v.frsD = a; v.frtD = b; v.frsE = c; v.frtE = d;
    return v;
  endfunction

  task automatic drive(input ins_t x, input int fl);
    hz.Tuse_rs    = x.tu_rs;
    hz.Tuse_rt    = x.tu_rt;
    hz.TnewD      = x.tnew;
    hz.A_rsD      = x.rs;
    hz.A_rtD      = x.rt;
    hz.AwriteD    = x.wr;
    hz.md_startD  = x.mds;
    hz.md_divD    = x.mdd;
    hz.md_accessD = x.mda;
    hz.flush      = 1'(fl);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " stall"},   int'(hz.stall),   0);
    chk({nm, " fwd_rsD"}, int'(hz.fwd_rsD), 0);
    chk({nm, " fwd_rtD"}, int'(hz.fwd_rtD), 0);
    chk({nm, " fwd_rsE"}, int'(hz.fwd_rsE), 0);
    chk({nm, " fwd_rtE"}, int'(hz.fwd_rtE), 0);
    chk({nm, " md_busy"}, int'(hz.md_busy), 0);
  endtask

  task automatic md_seq(input int dv, input int exp_st, input int exp_bz);
    int n, st, bz;
    repeat (3) begin @(negedge clk); drive(NOP(), 0); end
    @(negedge clk); drive(MD(dv), 0); #1;
    chk("md start stall", int'(hz.stall), 0);
    chk("md start busy", int'(hz.md_busy), 0);
    @(negedge clk); drive(MFLO(), 0); #1;
    chk("md busy lag", int'(hz.md_busy), 0);
    n = 0; st = 0; bz = 0;
    while (hz.stall && n < 40) begin
      st++;
      bz += int'(hz.md_busy);
      @(negedge clk); #1;
      n++;
    end
    chk("md wait bound", (n < 40) ? 1 : 0, 1);
    chk(dv != 0 ? "div stall cycles" : "mult stall cycles", st, exp_st);
    chk(dv != 0 ? "div busy cycles" : "mult busy cycles", bz, exp_bz);
    chk("md busy off", int'(hz.md_busy), 0);
    @(negedge clk); drive(NOP(), 0);
  endtask

  initial begin
    reset = 1'b0;
    drive(NOP(), 0);

    // D-stage instruction per cycle, flush, then expected stall and fwd_rsD/rtD/rsE/rtE
    tbl.push_back(V(LW(3),          0, 0, 0, 0, 0, 0));
    tbl.push_back(V(ALU(3, 5, 4),   0, 1, 0, 0, 0, 0));
    tbl.push_back(V(ALU(3, 5, 4),   0, 0, 0, 0, 0, 0));
    tbl.push_back(V(NOP(),          0, 0, 0, 0, 2, 0));
    tbl.push_back(V(NOP(),          0, 0, 0, 0, 0, 0));
    tbl.push_back(V(ALU(6, 7, 2),   0, 0, 0, 0, 0, 0));
    tbl.push_back(V(BR(2, 0),       0, 1, 0, 0, 0, 0));
    tbl.push_back(V(BR(2, 0),       0, 0, 1, 0, 0, 0));
    tbl.push_back(V(NOP(),          0, 0, 0, 0, 2, 0));
    tbl.push_back(V(NOP(),          0, 0, 0, 0, 0, 0));
    tbl.push_back(V(LW(7),          0, 0, 0, 0, 0, 0));
    tbl.push_back(V(NOP(),          0, 0, 0, 0, 0, 0));
    tbl.push_back(V(JR(7),          0, 1, 0, 0, 0, 0));
    tbl.push_back(V(JR(7),          0, 0, 2, 0, 0, 0));
    tbl.push_back(V(NOP(),          0, 0, 0, 0, 0, 0));
    tbl.push_back(V(LW(3),          0, 0, 0, 0, 0, 0));
    tbl.push_back(V(NOP(),          1, 0, 0, 0, 0, 0));
    tbl.push_back(V(ALU(3, 5, 4),   0, 0, 0, 0, 0, 0));
    tbl.push_back(V(NOP(),          0, 0, 0, 0, 0, 0));
    tbl.push_back(V(LW(3),          0, 0, 0, 0, 0, 0));
    tbl.push_back(V(ALU(3, 5, 4),   1, 1, 0, 0, 0, 0));
    tbl.push_back(V(ALU(3, 5, 4),   0, 0, 0, 0, 0, 0));
    tbl.push_back(V(NOP(),          0, 0, 0, 0, 0, 0));
    tbl.push_back(V(ALU(12, 13, 11), 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(ALU(15, 16, 14), 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(ALU(11, 14, 17), 0, 0, 1, 0, 0, 0));
    tbl.push_back(V(NOP(),          0, 0, 0, 0, 2, 1));
    tbl.push_back(V(NOP(),          0, 0, 0, 0, 0, 0));
    tbl.push_back(V(ALU(21, 22, 20), 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(ALU(21, 22, 20), 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(ALU(20, 20, 23), 0, 0, 1, 1, 0, 0));
    tbl.push_back(V(NOP(),          0, 0, 0, 0, 1, 1));
    tbl.push_back(V(NOP(),          0, 0, 0, 0, 0, 0));
    tbl.push_back(V(LW(25),         0, 0, 0, 0, 0, 0));
    tbl.push_back(V(NOUSE(25),      0, 0, 0, 0, 0, 0));
    tbl.push_back(V(NOP(),          0, 0, 0, 0, 0, 0));
    tbl.push_back(V(NOP(),          0, 0, 0, 0, 0, 0));
    tbl.push_back(V(LW(9),          0, 0, 0, 0, 0, 0));
    tbl.push_back(V(ALU(1, 9, 5),   0, 1, 0, 0, 0, 0));
    tbl.push_back(V(ALU(1, 9, 5),   0, 0, 0, 0, 0, 0));
    tbl.push_back(V(NOP(),          0, 0, 0, 0, 0, 2));
    tbl.push_back(V(NOP(),          0, 0, 0, 0, 0, 0));

    #2;
    chk_all_zero("reset");
    @(negedge clk); reset = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      drive(tbl[k].i, tbl[k].fl);
      #1;
      chk($sformatf("v%0d stall", k),   int'(hz.stall),   tbl[k].st);
      chk($sformatf("v%0d fwd_rsD", k), int'(hz.fwd_rsD), tbl[k].frsD);
      chk($sformatf("v%0d fwd_rtD", k), int'(hz.fwd_rtD), tbl[k].frtD);
      chk($sformatf("v%0d fwd_rsE", k), int'(hz.fwd_rsE), tbl[k].frsE);
      chk($sformatf("v%0d fwd_rtE", k), int'(hz.fwd_rtE), tbl[k].frtE);
      chk($sformatf("v%0d md_busy", k), int'(hz.md_busy), 0);
    end

    md_seq(0, 6, 5);
    md_seq(1, 11, 10);

    // Reset dropped in the middle of a load-use stall with the md unit busy.
    repeat (3) begin @(negedge clk); drive(NOP(), 0); end
    @(negedge clk); drive(MD(0), 0);
    @(negedge clk); drive(LW(3), 0);
    @(negedge clk); drive(ALU(3, 5, 4), 0); #1;
    chk("pre-reset stall", int'(hz.stall), 1);
    chk("pre-reset busy", int'(hz.md_busy), 1);
    #2; reset = 1'b0; #1;
    chk_all_zero("async reset");
    @(negedge clk); reset = 1'b1; #1;
    chk("post-reset stall", int'(hz.stall), 0);
    @(negedge clk); drive(ALU(6, 7, 0), 0); #1;
    chk("r0 writer stall", int'(hz.stall), 0);
    @(negedge clk); drive(BR(0, 0), 0); #1;
    chk("r0 beq stall", int'(hz.stall), 0);
    @(negedge clk); drive(LW(0), 0); #1;
    chk("r0 lw stall", int'(hz.stall), 0);
    @(negedge clk); drive(ALU(0, 0, 4), 0); #1;
    chk("r0 use stall", int'(hz.stall), 0);
    chk("r0 use fwd_rsD", int'(hz.fwd_rsD), 0);
    @(negedge clk); drive(NOP(), 0); #1;
    chk("r0 fwd_rsE", int'(hz.fwd_rsE), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
